// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU between two requesters; accept->rsp_valid 1 cycle, 1 op per 3 cycles.
// Backpressure: response held stable until rsp_ready; no request is accepted until the response handshake completes.
module alu_arbiter #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic                prio_q;
    logic                id_q;
    logic                grant;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [OP_W-1:0]     alu_op_q;
    logic                rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_carry_q;
    logic [DATA_W-1:0]   rsp_result_q;

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        grant = prio_q;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (!req0_valid && req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = (state_q == IDLE) && req1_valid &&  grant;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req0_ready || req1_ready) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            id_q         <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req0_ready) begin
                alu_a_q  <= req0_a;
                alu_b_q  <= req0_b;
                alu_op_q <= req0_op;
                id_q     <= 1'b0;
                prio_q   <= 1'b1;
            end else if (req1_ready) begin
                alu_a_q  <= req1_a;
                alu_b_q  <= req1_b;
                alu_op_q <= req1_op;
                id_q     <= 1'b1;
                prio_q   <= 1'b0;
            end
            // The ALU has had a full cycle on registered operands by the end of EXEC.
            if (state_q == EXEC) begin
                rsp_valid_q  <= 1'b1;
                rsp_id_q     <= id_q;
                rsp_result_q <= alu_result;
                rsp_zero_q   <= alu_zero;
                rsp_carry_q  <= alu_carry;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_carry  = rsp_carry_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model compared every cycle, plus directed literal checks.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0_valid = 0, req1_valid = 0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [2:0] req0_op = 0, req1_op = 0;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_result = 0;
    logic       alu_zero = 0, alu_carry = 0;
    logic       rsp_valid, rsp_ready = 0, rsp_id;
    logic [7:0] rsp_result;
    logic       rsp_zero, rsp_carry, busy;

    alu_arbiter #(.DATA_W(8), .OP_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, transaction level: an accepted op is "in the ALU" for one
    // cycle, then becomes an outstanding response until the consumer takes it.
    bit       m_in_alu = 0;
    bit       m_rsp_out = 0;
    bit       m_last_id = 1;
    bit [7:0] m_a = 0, m_b = 0;
    bit [2:0] m_op = 0;
    bit       m_id = 0, m_rid = 0, m_rz = 0, m_rc = 0;
    bit [7:0] m_rres = 0;

    function automatic bit m_idle();
        return !m_in_alu && !m_rsp_out;
    endfunction

    function automatic bit m_pick(input bit v0, input bit v1);
        if (v0 && v1) return ~m_last_id;
        return v1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_alu = 0; m_rsp_out = 0; m_last_id = 1;
            m_a = 0; m_b = 0; m_op = 0; m_id = 0;
            m_rid = 0; m_rres = 0; m_rz = 0; m_rc = 0;
        end else if (m_in_alu) begin
            m_in_alu = 0; m_rsp_out = 1;
            m_rid = m_id; m_rres = alu_result; m_rz = alu_zero; m_rc = alu_carry;
        end else if (m_rsp_out) begin
            if (rsp_ready) m_rsp_out = 0;
        end else if (req0_valid || req1_valid) begin
            m_id = m_pick(req0_valid, req1_valid);
            m_a  = m_id ? req1_a  : req0_a;
            m_b  = m_id ? req1_b  : req0_b;
            m_op = m_id ? req1_op : req0_op;
            m_last_id = m_id;
            m_in_alu  = 1;
        end
    end

    int cyc = 0;
    int acc_id[$];
    int acc_cyc[$];
    int acc1_cnt = 0;
    int rsp1_cnt = 0;

    always @(negedge clk) begin
        bit g, e0, e1;
        if (rst_n) begin
            g  = m_pick(req0_valid, req1_valid);
            e0 = m_idle() && req0_valid && !g;
            e1 = m_idle() && req1_valid &&  g;
            check("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
            check("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
            check("busy",       {31'd0, busy},       {31'd0, !m_idle()});
            check("rsp_valid",  {31'd0, rsp_valid},  {31'd0, m_rsp_out});
            check("rsp_id",     {31'd0, rsp_id},     {31'd0, m_rid});
            check("rsp_result", {24'd0, rsp_result}, {24'd0, m_rres});
            check("rsp_zero",   {31'd0, rsp_zero},   {31'd0, m_rz});
            check("rsp_carry",  {31'd0, rsp_carry},  {31'd0, m_rc});
            check("alu_a",      {24'd0, alu_a},      {24'd0, m_a});
            check("alu_b",      {24'd0, alu_b},      {24'd0, m_b});
            check("alu_opcode", {29'd0, alu_opcode}, {29'd0, m_op});
            if (req0_valid && req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
            if (req1_valid && req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(cyc); acc1_cnt++; end
            if (rsp_valid && rsp_ready && rsp_id) rsp1_cnt++;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 0;
        idle_inputs();
        #4 rst_n = 1;
    endtask

    initial begin
        int a1, b1;
        // Reset state
        #1 rst_n = 0;
        #1;
        check("reset rsp_valid", {31'd0, rsp_valid}, 0);
        check("reset busy",      {31'd0, busy}, 0);
        check("reset alu_a",     {24'd0, alu_a}, 0);
        check("reset rsp_result",{24'd0, rsp_result}, 0);
        @(posedge clk);
        #7 rst_n = 1;

        // Single op
        tick();
        req0_valid = 1; req0_a = 8'h12; req0_b = 8'h34; req0_op = 3'd0;
        alu_result = 8'h46; alu_zero = 0; alu_carry = 0; rsp_ready = 1;
        #1 check("single req0_ready", {31'd0, req0_ready}, 1);
        tick(); req0_valid = 0;
        #1 check("single busy", {31'd0, busy}, 1);
        check("single alu_a", {24'd0, alu_a}, 32'h12);
        check("single early rsp_valid", {31'd0, rsp_valid}, 0);
        tick();
        #1 check("single rsp_valid", {31'd0, rsp_valid}, 1);
        check("single rsp_id", {31'd0, rsp_id}, 0);
        check("single rsp_result", {24'd0, rsp_result}, 32'h46);
        tick();
        #1 check("single rsp_valid drop", {31'd0, rsp_valid}, 0);

        // Contention from reset
        do_reset();
        acc_id.delete(); acc_cyc.delete();
        tick();
        req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 3'd1;
        req1_valid = 1; req1_a = 8'h03; req1_b = 8'h04; req1_op = 3'd2;
        rsp_ready = 1; alu_result = 8'h5A;
        repeat (12) tick();
        idle_inputs();
        check("contention accepts", acc_id.size(), 4);
        for (int i = 0; i < acc_id.size() && i < 4; i++) begin
            check("contention order", acc_id[i], i % 2);
            if (i > 0) check("contention spacing", acc_cyc[i] - acc_cyc[i-1], 3);
        end
        repeat (3) tick();

        // Back-pressure
        tick();
        req1_valid = 1; req1_a = 8'hF0; req1_b = 8'h0F; req1_op = 3'd3;
        alu_result = 8'hFF; alu_zero = 0; alu_carry = 1; rsp_ready = 0;
        tick(); req1_valid = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            alu_result = 8'($urandom); alu_zero = 1'($urandom); alu_carry = 1'($urandom);
            req0_valid = 1; req1_valid = 1;
            #1 check("bp rsp_result", {24'd0, rsp_result}, 32'hFF);
            check("bp rsp_carry", {31'd0, rsp_carry}, 1);
            check("bp rsp_zero", {31'd0, rsp_zero}, 0);
            check("bp rsp_id", {31'd0, rsp_id}, 1);
            check("bp no ready", {30'd0, req0_ready, req1_ready}, 0);
            tick();
        end
        idle_inputs(); rsp_ready = 1;
        #1 check("bp still valid", {31'd0, rsp_valid}, 1);
        tick();
        #1 check("bp back to idle", {31'd0, busy}, 0);

        // Boundary flags
        tick();
        req0_valid = 1; req0_a = 8'h80; req0_b = 8'h80; req0_op = 3'd0;
        alu_result = 8'h00; alu_zero = 1; alu_carry = 1; rsp_ready = 1;
        tick(); req0_valid = 0;
        tick();
        #1 check("flags zero", {31'd0, rsp_zero}, 1);
        check("flags carry", {31'd0, rsp_carry}, 1);
        check("flags result", {24'd0, rsp_result}, 0);
        tick();

        // Reset during EXEC
        do_reset();
        tick();
        req0_valid = 1; req0_a = 8'hAA; req0_b = 8'h55; req0_op = 3'd5; rsp_ready = 1;
        tick(); req0_valid = 0;
        #1 check("mid alu_a loaded", {24'd0, alu_a}, 32'hAA);
        rst_n = 0;
        #1 check("mid rst rsp_valid", {31'd0, rsp_valid}, 0);
        check("mid rst busy", {31'd0, busy}, 0);
        check("mid rst alu", {21'd0, alu_a, alu_opcode}, 0);
        #3 rst_n = 1;
        tick();
        req1_valid = 1; req1_a = 8'h07; req1_b = 8'h09; req1_op = 3'd2; alu_result = 8'h10;
        #1 check("post rst req1_ready", {31'd0, req1_ready}, 1);
        tick(); req1_valid = 0;
        tick();
        #1 check("post rst rsp_id", {31'd0, rsp_id}, 1);
        check("post rst rsp_valid", {31'd0, rsp_valid}, 1);
        tick();
        req0_valid = 1; req1_valid = 1;
        #1 check("post rst prio", {30'd0, req0_ready, req1_ready}, 32'h2);
        tick(); idle_inputs();
        repeat (3) tick();

        // Withdrawn request while busy
        a1 = acc1_cnt; b1 = rsp1_cnt;
        req0_valid = 1; req0_a = 8'h33;
        tick(); req0_valid = 0; req1_valid = 1;
        #1 check("withdraw no ready", {31'd0, req1_ready}, 0);
        tick(); req1_valid = 0;
        repeat (5) tick();
        check("withdraw no grant", acc1_cnt, a1);
        check("withdraw no rsp", rsp1_cnt, b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            req0_valid = 1'($urandom); req1_valid = 1'($urandom);
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 3'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 3'($urandom);
            alu_result = 8'($urandom); alu_zero = 1'($urandom); alu_carry = 1'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        idle_inputs(); rsp_ready = 1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU instance (A, B, Opcode -> Result, Zero, Carry) between two requesters.
- Uses round-robin arbitration with valid/ready handshakes on both request channels and the response channel.
- Registers operands into the ALU, captures Result/Zero/Carry one cycle later, and returns them tagged with the requester id.
- Sits between the two datapath clients and the alu_top instance.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- OP_W, 3, opcode width; must match the ALU.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  DATA_W  requester 0 operand A
- req0_b  in  DATA_W  requester 0 operand B
- req0_op  in  OP_W  requester 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as above, for requester 1
- alu_a  out  DATA_W  registered operand to ALU A
- alu_b  out  DATA_W  registered operand to ALU B
- alu_opcode  out  OP_W  registered opcode to ALU Opcode
- alu_result  in  DATA_W  ALU Result
- alu_zero  in  1  ALU Zero
- alu_carry  in  1  ALU Carry
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the response (0/1)
- rsp_result  out  DATA_W  captured result
- rsp_zero  out  1  captured Zero
- rsp_carry  out  1  captured Carry
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state=IDLE, prio=0.
  - alu_a=0, alu_b=0, alu_opcode=0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_carry=0, busy=0.
  - Any in-flight transaction is dropped without a response. After rst_n rises, the block is in IDLE.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant selection (combinational):
  - If only one reqN_valid is high, grant=N.
  - If both are high, grant=prio.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. At most one ready is high per cycle.
  - Ready may depend combinationally on valid.
- IDLE, on accept (reqN_valid && reqN_ready at an edge):
  - alu_a/alu_b/alu_opcode <= reqN_a/b/op.
  - id_q <= N; prio <= ~N.
  - Next state EXEC.
- EXEC (one cycle, lets the ALU settle):
  - At the edge: rsp_result/rsp_zero/rsp_carry <= alu_result/zero/carry, rsp_id <= id_q, rsp_valid <= 1.
  - Next state RESP.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready at an edge: rsp_valid <= 0, next state IDLE.
  - No new request is accepted in RESP, even if rsp_ready is high.
- Operand stability: alu_a/alu_b/alu_opcode hold their last accepted values in all states and change only on accept. Requesters may change or drop inputs after their handshake.
- Timing:
  - With the accept at edge k, rsp_valid is high from edge k+1.
  - With rsp_ready held high, the response handshake is at edge k+2 and the earliest next accept is at edge k+3.
  - Maximum throughput: 1 op / 3 cycles.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...; neither waits more than one transaction.
- A valid raised while busy waits; it must be held until ready. Deasserting valid before ready is allowed, and no grant results.
- busy = (state != IDLE).

Test Plan:
- Single op, stub ALU: reset; req0 a=0x12, b=0x34, op=3'd0; stub returns result=0x46, zero=0, carry=0; rsp_ready=1. Required: req0_ready at edge 1, rsp_valid one cycle later with rsp_id=0, rsp_result=0x46, and rsp_valid low after the next edge.
- Contention: both valid from reset with different operands, rsp_ready=1. Required: grant order 0,1,0,1 over 4 transactions; rsp_id matches; an accept every 3 cycles.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid, with stub outputs changing every cycle. Required: rsp_result/zero/carry/id frozen at the captured values (e.g. 0xFF, zero=0, carry=1); no reqN_ready while waiting; state returns to IDLE on the first edge with rsp_ready=1.
- Boundary flags: stub drives result=0x00, zero=1, carry=1. Required: rsp_zero=1, rsp_carry=1, rsp_result=0x00.
- Reset mid-operation: assert rst_n low during EXEC, asynchronously between edges. Required: rsp_valid, busy, and alu_* go to 0 immediately; after release, req1-only traffic is granted normally with prio=0.
- Withdrawn request: req1_valid pulses for one cycle while busy. Required: no grant and no response for requester 1.
